// File: rtl/kernel_applier_if.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_applier_if
//  Description : Window-in / pixel-out bus for kernel_applier.
//                master : drives kernel taps, pixel window, window_valid and
//                         pixel_ready; observes window_ready, pixel_out,
//                         pixel_valid and busy.
//                slave  : the filter block (mirror of master).
//  Parameters  : N        taps per kernel / pixels per window
//                PIXEL_W  unsigned pixel width
//  Revision    : 1.0  initial release
// ============================================================================
interface kernel_applier_if #(
    parameter int N       = 25,
    parameter int PIXEL_W = 8
);
    logic signed [31:0]       kernel      [0:N-1];
    logic        [PIXEL_W-1:0] window_data [0:N-1];
    logic                     window_valid;
    logic                     window_ready;
    logic        [PIXEL_W-1:0] pixel_out;
    logic                     pixel_valid;
    logic                     pixel_ready;
    logic                     busy;

    modport master (
        output kernel, window_data, window_valid, pixel_ready,
        input  window_ready, pixel_out, pixel_valid, busy
    );

    modport slave (
        input  kernel, window_data, window_valid, pixel_ready,
        output window_ready, pixel_out, pixel_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/kernel_applier.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_applier
//  Description : Applies an N-tap signed fixed-point kernel to an N-pixel
//                window with one multiply-accumulate per clock, then shifts
//                out the fractional bits, clamps to the pixel range and holds
//                the result until the consumer takes it.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high reset
//                bus    kernel_applier_if.slave (window in, pixel out, busy)
//  Options     : KERNEL_ROUNDING_EN  round half up before the shift instead
//                                    of truncating toward -infinity
//  Revision    : 1.0  initial release
// ============================================================================
module kernel_applier #(
    parameter int N               = 25,
    parameter int FRACTIONAL_BITS = 8,
    parameter int PIXEL_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    kernel_applier_if.slave  bus
);
    // Product of a zero-extended pixel and a 32-bit signed tap.
    localparam int PROD_W  = PIXEL_W + 33;
    // Headroom for N products, never narrower than 48 bits.
    localparam int ACC_MIN = PROD_W + $clog2(N) + 1;
    localparam int ACC_W   = (ACC_MIN > 48) ? ACC_MIN : 48;
    localparam int TAP_W   = $clog2(N + 1);

    localparam logic        [TAP_W-1:0] LAST_TAP = TAP_W'(N - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX  =
        {{(ACC_W - PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic        [PIXEL_W-1:0]  pix_q [0:N-1];
    logic signed [31:0]         ker_q [0:N-1];
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic        [TAP_W-1:0]    tap_q, tap_d;
    logic        [PIXEL_W-1:0]  pixel_out_q, pixel_out_d;

    logic                       accept;
    logic signed [PROD_W-1:0]   pix_ext, ker_ext, prod;
    logic signed [ACC_W-1:0]    sum, biased, shifted;
    logic        [PIXEL_W-1:0]  clamped;

    // ------------------------------------------------------------------
    // Datapath: current tap product, running sum including it, and the
    // scaled/clamped pixel used on the final tap.
    // ------------------------------------------------------------------
    always_comb begin
        pix_ext = {{(PROD_W - PIXEL_W){1'b0}}, pix_q[tap_q]};
        ker_ext = {{(PROD_W - 32){ker_q[tap_q][31]}}, ker_q[tap_q]};
        prod    = pix_ext * ker_ext;
        sum     = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
`ifdef KERNEL_ROUNDING_EN
        biased  = sum + ({{(ACC_W - 1){1'b0}}, 1'b1} << (FRACTIONAL_BITS - 1));
`else
        biased  = sum;
`endif
        shifted = biased >>> FRACTIONAL_BITS;
        if (shifted[ACC_W-1]) begin
            clamped = '0;
        end else if (shifted > PIX_MAX) begin
            clamped = '1;
        end else begin
            clamped = shifted[PIXEL_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        pixel_out_d = pixel_out_q;
        accept      = bus.window_valid && (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    acc_d   = '0;
                    tap_d   = '0;
                end
            end
            MAC: begin
                acc_d = sum;
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == LAST_TAP) begin
                    state_d     = OUT;
                    pixel_out_d = clamped;
                end
            end
            OUT: begin
                // Returning to IDLE (not straight to MAC) keeps release and
                // accept in separate cycles.
                if (bus.pixel_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            pixel_out_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            pixel_out_q <= pixel_out_d;
        end
    end

    // Snapshot of the window and kernel so later input changes cannot
    // disturb the result in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_q <= bus.window_data;
            ker_q <= bus.kernel;
        end
    end

    assign bus.window_ready = (state_q == IDLE);
    assign bus.pixel_valid  = (state_q == OUT);
    assign bus.busy         = (state_q != IDLE);
    assign bus.pixel_out    = pixel_out_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_applier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kernel_applier
//  Description : Self-checking bench for kernel_applier with randomized
//                windows/kernels compared against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kernel_applier;
    localparam int N   = 25;
    localparam int FB  = 8;
    localparam int PW  = 8;
    localparam int MAXP = (1 << PW) - 1;

    typedef logic signed [31:0] kern_t [N];
    typedef logic [PW-1:0]      win_t  [N];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    kernel_applier_if #(.N(N), .PIXEL_W(PW)) bus();

    kernel_applier #(
        .N               (N),
        .FRACTIONAL_BITS (FB),
        .PIXEL_W         (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: dot product, optional half-LSB bias, floor shift, clamp.
    function automatic int model(input kern_t k, input win_t p);
        longint s = 0;
        for (int t = 0; t < N; t++) s += longint'(p[t]) * longint'(k[t]);
`ifdef KERNEL_ROUNDING_EN
        s += longint'(1) << (FB - 1);
`endif
        s = s >>> FB;
        if (s < 0) return 0;
        if (s > MAXP) return MAXP;
        return int'(s);
    endfunction

    task automatic rand_window(output win_t p, input int lo);
        for (int t = 0; t < N; t++) p[t] = PW'($urandom_range(MAXP, lo));
    endtask

    task automatic rand_kernel(output kern_t k, input int lo, input int hi);
        for (int t = 0; t < N; t++) k[t] = 32'(int'($urandom_range(hi - lo, 0)) + lo);
    endtask

    task automatic zero_kernel(output kern_t k);
        for (int t = 0; t < N; t++) k[t] = '0;
    endtask

    // Offers one window; returns edges from accept to pixel_valid.
    task automatic run_window(input kern_t k, input win_t p, input bit scramble,
                              output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        bus.kernel       = k;
        bus.window_data  = p;
        bus.window_valid = 1'b1;
        n = 0;
        while (!bus.window_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.window_ready) begin
            to = 1'b1;
            bus.window_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.window_valid = 1'b0;
        if (scramble) begin
            for (int t = 0; t < N; t++) begin
                bus.kernel[t]      = '0;
                bus.window_data[t] = PW'($urandom);
            end
        end
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus.pixel_valid && n < 200);
        lat = n;
        to  = !bus.pixel_valid;
    endtask

    task automatic release_px;
        bus.pixel_ready = 1'b1;
        @(posedge clk); #1;
        bus.pixel_ready = 1'b0;
    endtask

    task automatic test_reset;
        kern_t k;
        win_t  p;
        zero_kernel(k);
        rand_window(p, 0);
        bus.kernel       = k;
        bus.window_data  = p;
        bus.window_valid = 1'b0;
        bus.pixel_ready  = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.window_ready !== 1'b1) begin errors++; $display("FAIL reset_window_ready got %b want 1", bus.window_ready); end
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid got %b want 0", bus.pixel_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.pixel_out !== 8'd0) begin errors++; $display("FAIL reset_pixel_out got %0d want 0", bus.pixel_out); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single(input string name, input int k12, input int p12, input int want);
        kern_t k;
        win_t  p;
        int    lat;
        bit    to;
        zero_kernel(k);
        rand_window(p, 0);
        k[12] = 32'(k12);
        p[12] = PW'(p12);
        run_window(k, p, 1'b0, lat, to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout got timeout want pixel_valid", name); end
        checks++; if (lat != N) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, N); end
        checks++; if (bus.pixel_out !== PW'(want)) begin errors++; $display("FAIL %s_value got %0d want %0d", name, bus.pixel_out, want); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", name, bus.busy); end
        release_px();
        checks++; if (bus.pixel_valid !== 1'b0 || bus.window_ready !== 1'b1) begin
            errors++; $display("FAIL %s_release got valid=%b ready=%b want valid=0 ready=1", name, bus.pixel_valid, bus.window_ready);
        end
    endtask

    task automatic test_identity;
        test_single("identity", 256, 100, 100);
    endtask

    task automatic test_rounding;
`ifdef KERNEL_ROUNDING_EN
        test_single("rounding", 384, 101, 152);
`else
        test_single("rounding", 384, 101, 151);
`endif
    endtask

    task automatic test_clamp;
        test_single("clamp_low", -256, 50, 0);
        test_single("clamp_high", 512, 200, 255);
    endtask

    task automatic test_random;
        kern_t k;
        win_t  p;
        int    lat, want;
        bit    to;
        for (int i = 0; i < 10; i++) begin
            rand_window(p, 0);
            if (i % 3 == 2) rand_kernel(k, -300, 300);
            else            rand_kernel(k, -20, 40);
            want = model(k, p);
            run_window(k, p, 1'b0, lat, to);
            checks++; if (to || lat != N) begin errors++; $display("FAIL random%0d_latency got %0d (timeout=%b) want %0d", i, lat, to, N); end
            checks++; if (bus.pixel_out !== PW'(want)) begin errors++; $display("FAIL random%0d_value got %0d want %0d", i, bus.pixel_out, want); end
            release_px();
        end
    endtask

    task automatic test_backpressure;
        kern_t k;
        win_t  p;
        int    lat, want;
        bit    to;
        rand_kernel(k, 1, 40);
        rand_window(p, 1);
        want = model(k, p);
        run_window(k, p, 1'b1, lat, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got timeout want pixel_valid"); end
        bus.window_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (bus.pixel_valid !== 1'b1 || bus.pixel_out !== PW'(want)) begin
                errors++; $display("FAIL bp_hold%0d got valid=%b out=%0d want valid=1 out=%0d", c, bus.pixel_valid, bus.pixel_out, want);
            end
            checks++; if (bus.window_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b want 0", c, bus.window_ready); end
            @(posedge clk); #1;
        end
        bus.window_valid = 1'b0;
        release_px();
        checks++; if (bus.window_ready !== 1'b1) begin errors++; $display("FAIL bp_after got ready=%b want 1", bus.window_ready); end
    endtask

    task automatic test_reset_mid;
        kern_t k;
        win_t  p;
        int    lat, want, n;
        bit    to, seen;
        rand_kernel(k, 1, 40);
        rand_window(p, 1);
        bus.kernel       = k;
        bus.window_data  = p;
        bus.window_valid = 1'b1;
        n = 0;
        while (!bus.window_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.window_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_inflight got busy=%b want 1", bus.busy); end
        reset = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.window_ready !== 1'b1 || bus.pixel_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got busy=%b ready=%b valid=%b want 0/1/0", bus.busy, bus.window_ready, bus.pixel_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        bus.pixel_ready = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.pixel_valid) seen = 1'b1;
        end
        bus.pixel_ready = 1'b0;
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_pixel got pixel_valid=1 want never"); end
        checks++; if (bus.window_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", bus.window_ready); end
        rand_kernel(k, -20, 40);
        rand_window(p, 0);
        want = model(k, p);
        run_window(k, p, 1'b0, lat, to);
        checks++; if (to || bus.pixel_out !== PW'(want)) begin
            errors++; $display("FAIL rstmid_next got %0d (timeout=%b) want %0d", bus.pixel_out, to, want);
        end
        release_px();
    endtask

    task automatic test_back_to_back;
        kern_t k;
        win_t  p;
        int    want, pixels, n;
        int    acc_edges[$];
        bit    will_accept;
        rand_kernel(k, -20, 40);
        rand_window(p, 0);
        want = model(k, p);
        bus.kernel       = k;
        bus.window_data  = p;
        bus.window_valid = 1'b1;
        bus.pixel_ready  = 1'b1;
        pixels = 0;
        for (int e = 1; e <= 90; e++) begin
            will_accept = bus.window_ready && bus.window_valid;
            @(posedge clk); #1;
            if (will_accept) acc_edges.push_back(e);
            if (bus.pixel_valid) begin
                pixels++;
                checks++; if (bus.pixel_out !== PW'(want)) begin errors++; $display("FAIL b2b_value got %0d want %0d", bus.pixel_out, want); end
                checks++; if (bus.window_ready !== 1'b0) begin errors++; $display("FAIL b2b_overlap got ready=1 while valid want 0"); end
            end
        end
        bus.window_valid = 1'b0;
        checks++; if (acc_edges.size() < 3) begin
            errors++; $display("FAIL b2b_accepts got %0d want >=3", acc_edges.size());
        end else begin
            checks++; if (acc_edges[1] - acc_edges[0] != N + 2 || acc_edges[2] - acc_edges[1] != N + 2) begin
                errors++; $display("FAIL b2b_spacing got %0d,%0d want %0d", acc_edges[1] - acc_edges[0], acc_edges[2] - acc_edges[1], N + 2);
            end
        end
        checks++; if (pixels < 3) begin errors++; $display("FAIL b2b_pixels got %0d want >=3", pixels); end
        n = 0;
        while (bus.busy && n < 60) begin @(posedge clk); #1; n++; end
        bus.pixel_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got busy=%b want 0", bus.busy); end
    endtask

    initial begin
        reset            = 1'b1;
        bus.window_valid = 1'b0;
        bus.pixel_ready  = 1'b0;
        test_reset();
        test_identity();
        test_rounding();
        test_clamp();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
